// File: rtl/psg_tone_bank_if.sv
// rtl/psg_tone_bank_if.sv - register-write, acquire and sample bundle for psg_tone_bank
interface psg_tone_bank_if #(
    parameter int NUM_CH   = 3,
    parameter int PERIOD_W = 10,
    parameter int ATT_W    = 4,
    parameter int OUT_W    = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                       acquire;
    logic                       wr_en;
    logic [CH_W-1:0]            wr_ch;
    logic                       wr_sel;
    logic [PERIOD_W-1:0]        wr_data;
    logic signed [OUT_W-1:0]    sample;
    logic                       sample_valid;
    logic [NUM_CH-1:0]          ch_level;

    modport master (
        output acquire, wr_en, wr_ch, wr_sel, wr_data,
        input  sample, sample_valid, ch_level
    );

    modport slave (
        input  acquire, wr_en, wr_ch, wr_sel, wr_data,
        output sample, sample_valid, ch_level
    );
endinterface

// File: rtl/psg_tone_bank.sv
// rtl/psg_tone_bank.sv - multi-channel square-wave tone generator with 2-stage mixing pipeline
module psg_tone_bank #(
    parameter int NUM_CH   = 3,
    parameter int PERIOD_W = 10,
    parameter int ATT_W    = 4,
    parameter int OUT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    psg_tone_bank_if.slave   bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SUM_W = OUT_W + $clog2(NUM_CH);
    localparam int FS    = ((2 ** (OUT_W - 1)) - 1) / NUM_CH;

    localparam logic [OUT_W-1:0]        FS_V  = OUT_W'(FS);
    localparam logic [ATT_W-1:0]        MUTE  = '1;
    localparam logic [PERIOD_W-1:0]     ONE_P = PERIOD_W'(1);
    localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_S = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [PERIOD_W-1:0]     period_q [NUM_CH];
    logic [PERIOD_W-1:0]     period_d [NUM_CH];
    logic [ATT_W-1:0]        att_q    [NUM_CH];
    logic [ATT_W-1:0]        att_d    [NUM_CH];
    logic [PERIOD_W-1:0]     count_q  [NUM_CH];
    logic [PERIOD_W-1:0]     count_d  [NUM_CH];
    logic [OUT_W-1:0]        amp      [NUM_CH];
    logic signed [OUT_W-1:0] v_q      [NUM_CH];
    logic signed [OUT_W-1:0] v_d      [NUM_CH];
    logic [NUM_CH-1:0]       level_q, level_d;
    logic                    v_valid_q;
    logic signed [SUM_W-1:0] sum;
    logic signed [OUT_W-1:0] sample_q, sample_d;
    logic                    sample_valid_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            amp[i] = (att_q[i] == MUTE) ? '0 : (FS_V >> att_q[i]);
        end
    end

    // Counters and stage 1 see pre-write period/att; writes land on the same edge.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            att_d[i]    = att_q[i];
            count_d[i]  = count_q[i];
            v_d[i]      = v_q[i];
            if (bus.acquire) begin
                if (count_q[i] <= ONE_P) begin
                    count_d[i] = period_q[i];
                    level_d[i] = (period_q[i] <= ONE_P) ? 1'b1 : ~level_q[i];
                end else begin
                    count_d[i] = count_q[i] - ONE_P;
                end
                v_d[i] = level_d[i] ? $signed(amp[i]) : -$signed(amp[i]);
            end
            if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
                if (bus.wr_sel) begin
                    att_d[i] = bus.wr_data[ATT_W-1:0];
                end else begin
                    period_d[i] = bus.wr_data;
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SUM_W'(v_q[i]);
        end
        sample_d = sample_q;
        if (v_valid_q) begin
            if (sum > MAX_S) begin
                sample_d = $signed(MAX_S[OUT_W-1:0]);
            end else if (sum < MIN_S) begin
                sample_d = $signed(MIN_S[OUT_W-1:0]);
            end else begin
                sample_d = $signed(sum[OUT_W-1:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                att_q[i]    <= '1;
                count_q[i]  <= '0;
                v_q[i]      <= '0;
            end
            level_q        <= '1;
            v_valid_q      <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                att_q[i]    <= att_d[i];
                count_q[i]  <= count_d[i];
                v_q[i]      <= v_d[i];
            end
            level_q        <= level_d;
            v_valid_q      <= bus.acquire;
            sample_q       <= sample_d;
            sample_valid_q <= v_valid_q;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.ch_level     = level_q;
endmodule

// File: tb/tb_psg_tone_bank.sv
// tb/tb_psg_tone_bank.sv - randomized and directed bench for psg_tone_bank
module tb_psg_tone_bank;
    localparam int NUM_CH   = 3;
    localparam int PERIOD_W = 10;
    localparam int ATT_W    = 4;
    localparam int OUT_W    = 16;
    localparam int FS       = ((1 << (OUT_W - 1)) - 1) / NUM_CH;
    localparam int ATT_MUTE = (1 << ATT_W) - 1;
    localparam int S_MAX    = (1 << (OUT_W - 1)) - 1;
    localparam int S_MIN    = -(1 << (OUT_W - 1));

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psg_tone_bank_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .ATT_W(ATT_W), .OUT_W(OUT_W)) bus ();

    psg_tone_bank #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .ATT_W(ATT_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference: each channel tracks ticks left in its current half-wave.
    int m_per [NUM_CH];
    int m_att [NUM_CH];
    int m_left[NUM_CH];
    int m_lvl [NUM_CH];
    int exp_val[$];
    int exp_due[$];
    int last_sample;
    int edge_n = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic int amp_of(input int att);
        return (att == ATT_MUTE) ? 0 : (FS >> att);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_per[c]  = 0;
            m_att[c]  = ATT_MUTE;
            m_left[c] = 0;
            m_lvl[c]  = 1;
        end
        exp_val.delete();
        exp_due.delete();
        last_sample = 0;
    endtask

    task automatic step(input bit rst, input bit acq, input bit wen, input int ch,
                        input bit sel, input int data);
        int s;
        int lv;
        @(negedge clk);
        reset        = rst;
        bus.acquire  = acq;
        bus.wr_en    = wen;
        bus.wr_ch    = ch[1:0];
        bus.wr_sel   = sel;
        bus.wr_data  = data[PERIOD_W-1:0];
        @(posedge clk);
        edge_n++;
        if (rst) begin
            model_reset();
        end else begin
            if (acq) begin
                s = 0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_left[c] == 0) begin
                        m_lvl[c]  = (m_per[c] <= 1) ? 1 : 1 - m_lvl[c];
                        m_left[c] = (m_per[c] > 1) ? m_per[c] - 1 : 0;
                    end else begin
                        m_left[c] = m_left[c] - 1;
                    end
                    s += m_lvl[c] ? amp_of(m_att[c]) : -amp_of(m_att[c]);
                end
                if (s > S_MAX) s = S_MAX;
                if (s < S_MIN) s = S_MIN;
                exp_val.push_back(s);
                exp_due.push_back(edge_n + 1);
            end
            if (wen && ch < NUM_CH) begin
                if (sel) m_att[ch] = data % (1 << ATT_W);
                else     m_per[ch] = data % (1 << PERIOD_W);
            end
        end
        #1;
        if (exp_due.size() > 0 && exp_due[0] == edge_n) begin
            check_eq("valid", int'(bus.sample_valid), 1);
            check_eq("sample", int'($signed(bus.sample)), exp_val[0]);
            last_sample = exp_val[0];
            void'(exp_val.pop_front());
            void'(exp_due.pop_front());
        end else begin
            check_eq("valid_idle", int'(bus.sample_valid), 0);
            check_eq("sample_hold", int'($signed(bus.sample)), last_sample);
        end
        lv = 0;
        for (int c = 0; c < NUM_CH; c++) lv |= (m_lvl[c] << c);
        check_eq("ch_level", int'(bus.ch_level), lv);
    endtask

    task automatic idle_acq(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input bit sel, input int data);
        step(0, 0, 1, ch, sel, data);
    endtask

    initial begin
        reset       = 1'b1;
        bus.acquire = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_ch   = '0;
        bus.wr_sel  = 1'b0;
        bus.wr_data = '0;
        model_reset();

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_eq("reset_level", int'(bus.ch_level), 7);

        // Muted after reset
        idle_acq(10);
        check_eq("muted_sample", int'($signed(bus.sample)), 0);

        // Single channel period 3
        wr(0, 0, 3);
        wr(0, 1, 0);
        idle_acq(3);
        check_eq("p3_first_low", int'($signed(bus.sample)), -FS);
        idle_acq(9);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Full scale, then partial attenuation
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            wr(c, 0, 0);
            wr(c, 1, 0);
        end
        idle_acq(4);
        check_eq("full_scale", int'($signed(bus.sample)), 32766);
        wr(1, 1, 1);
        wr(2, 1, 15);
        idle_acq(3);
        check_eq("att_mix", int'($signed(bus.sample)), 16383);

        // Period change mid half-wave
        step(1, 0, 0, 0, 0, 0);
        wr(0, 0, 5);
        wr(0, 1, 0);
        idle_acq(3);
        step(0, 1, 1, 0, 0, 2);
        idle_acq(14);

        // Attenuation write coincident with acquire, invalid channel write
        step(0, 1, 1, 0, 1, 2);
        idle_acq(3);
        check_eq("att2_amp", int'($signed(bus.sample)) * ((int'($signed(bus.sample)) < 0) ? -1 : 1), FS >> 2);
        step(0, 1, 1, 3, 0, 7);
        step(0, 1, 1, 3, 1, 0);
        idle_acq(6);

        // Reset with a sample in flight
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_eq("rst_inflight_valid", int'(bus.sample_valid), 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("rst_inflight_sample", int'($signed(bus.sample)), 0);
        check_eq("rst_inflight_level", int'(bus.ch_level), 7);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit r_rst, r_acq, r_wen, r_sel;
            int r_ch, r_data;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_acq  = ($urandom_range(0, 3) != 0);
            r_wen  = ($urandom_range(0, 3) == 0);
            r_ch   = $urandom_range(0, 3);
            r_sel  = $urandom_range(0, 1);
            r_data = r_sel ? $urandom_range(0, 15) : $urandom_range(0, 9);
            step(r_rst, r_acq, r_wen, r_ch, r_sel, r_data);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/psg_tone_bank.md
Name: psg_tone_bank

Overview:
Parametrised multi-channel square-wave tone generator for the SMS PSG path. It replaces the single-channel step/divider synthesiser with per-channel period down-counters, so no divider is needed. Each channel has a period register and an attenuation register. A 2-stage pipeline mixes all channels into one signed PCM sample per acquire tick, and that sample feeds the audio output FIFO/DAC interface.

Parameters:
NUM_CH, 3, number of tone channels (1..8)
PERIOD_W, 10, width of period registers and tone counters
ATT_W, 4, width of attenuation registers; the all-ones value means mute
OUT_W, 16, signed output sample width

Ports:
clk  input  1  system clock; only clock in the block
reset  input  1  synchronous, active-high reset
acquire  input  1  sample tick; one-cycle pulse, may be held high every cycle
wr_en  input  1  register write strobe; accepted every cycle, no backpressure
wr_ch  input  max(1,$clog2(NUM_CH))  target channel; a value >= NUM_CH makes the write ignored
wr_sel  input  1  0 = period register, 1 = attenuation register
wr_data  input  PERIOD_W  write data; attenuation uses wr_data[ATT_W-1:0]
sample  output  OUT_W  signed mixed sample
sample_valid  output  1  high for one cycle per accepted acquire
ch_level  output  NUM_CH  current polarity bit of each channel (debug/visualiser)

Behaviour:
- Clock is clk. Reset is synchronous and active-high, sampled only on the rising edge of clk. reset has priority over acquire and wr_en in the same cycle.
- Reset values:
  - period[i] = 0, att[i] = all-ones (muted), count[i] = 0, ch_level = all-ones.
  - Both pipeline stages cleared; sample = 0, sample_valid = 0.
- Derived constants:
  - FS = floor((2^(OUT_W-1)-1)/NUM_CH); defaults give FS = 10922.
  - amp[i] = 0 if att[i] is all-ones, else FS >> att[i].
- Register writes take effect on the clk edge where wr_en=1:
  - period write: period[wr_ch] <= wr_data. The counter is not touched; the new period is first used at that channel's next reload.
  - attenuation write: att[wr_ch] <= wr_data[ATT_W-1:0].
- Tone counter, per channel, on each clk edge with acquire=1:
  - if count <= 1: count <= period (old value if a period write lands on the same edge). ch_level toggles, except when period <= 1, where ch_level is forced to 1 (constant high, SMS behaviour).
  - else: count <= count - 1.
  - Result: the half-period is exactly period ticks for period >= 2.
  - No activity when acquire=0.
- Pipeline (accepts a new acquire every cycle, latency 2):
  - Stage 1, on the same edge as the counter update: v[i] <= ch_level_next[i] ? +amp[i] : -amp[i]. It uses the post-update polarity and the att value before any same-edge write.
  - Stage 2, next edge: sample <= saturate(sum of v[i]) to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]. Saturation is unreachable with the derived FS, but it is still required. Sum width is OUT_W+$clog2(NUM_CH).
  - sample_valid is high exactly two cycles after each acquire pulse; back-to-back acquires give back-to-back valids.
  - sample holds its last value while sample_valid=0.
- Reset during an in-flight sample: that sample is dropped. sample_valid is 0 on the cycle after reset and stays 0 until two cycles after the first post-reset acquire.
- Arithmetic is two's complement throughout; amp is non-negative and at most FS.

Test Plan:
- Reset, then acquire every cycle for 10 cycles, no writes -> sample_valid rises 2 cycles after the first acquire; every sample = 0 (all channels muted); ch_level = 3'b111 throughout.
- ch0: period=3, att=0; acquire every cycle -> samples from ticks 1-3 = -10922, ticks 4-6 = +10922, ticks 7-9 = -10922; ch_level[0] toggles every 3 ticks.
- All channels period=0, att=0 -> sample = +32766 every tick. Then ch1 att=1 and ch2 att=15 -> sample = 10922+5461+0 = 16383.
- ch0 period=5, running. Write period=2 two ticks after a reload -> the current half-period still lasts 5 ticks; the following half-periods last 2 ticks.
- Attenuation write (ch0 att 0->2) on the same edge as acquire -> that tick's sample uses amp 10922; the next tick uses 2730. A write with wr_ch=3 leaves all registers unchanged.
- Assert reset one cycle after acquire while a sample is in flight -> no sample_valid for that acquire; sample=0. All registers return to reset values and ch_level = 3'b111.
